// File: rtl/fc_neuron_stream.sv
// fc_neuron_stream: time-multiplexed FC neuron dot product z = sum(x[i]*w[i]).
// Consumes LANES activation/weight pairs per beat, accumulates over ceil(IN/LANES) beats,
// and presents the sum through a valid/ready output register.
// Optional macro FC_NEURON_RELU_EN clamps negative results to zero on the output load.
module fc_neuron_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IN    = 84,
    parameter int unsigned LANES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [LANES*WIDTH-1:0]           s_x,
    input  logic [LANES*WIDTH-1:0]           s_w,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [2*WIDTH+$clog2(IN)-1:0]    m_z
);

    localparam int unsigned BEATS  = (IN + LANES - 1) / LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned ACC_W  = 2 * WIDTH + $clog2(IN);

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          beat_cnt;
    logic                      accept_c;
    logic                      first_c;
    logic                      last_c;
    logic signed [PROD_W-1:0]  prod_c [LANES];
    logic signed [PROD_W-1:0]  prod_q [LANES];
    logic                      p1_valid;
    logic                      p1_first;
    logic                      p1_last;
    logic signed [ACC_W-1:0]   lane_sum_c;
    logic signed [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]          z_c;

    assign accept_c = s_valid && s_ready;
    assign first_c  = (beat_cnt == '0);
    assign last_c   = (beat_cnt == CNT_W'(BEATS - 1));

    // Per-lane signed products; lanes past the end of the vector contribute zero.
    always_comb begin
        for (int k = 0; k < int'(LANES); k++) begin
            prod_c[k] = '0;
            if ((32'(beat_cnt) * LANES + 32'(k)) < IN) begin
                prod_c[k] = PROD_W'($signed(s_x[k*WIDTH +: WIDTH]))
                          * PROD_W'($signed(s_w[k*WIDTH +: WIDTH]));
            end
        end
    end

    // Sign-extended sum of the registered lane products.
    always_comb begin
        lane_sum_c = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane_sum_c = lane_sum_c + ACC_W'(prod_q[k]);
        end
    end

    // Output value as loaded into the result register.
    always_comb begin
        z_c = acc;
`ifdef FC_NEURON_RELU_EN
        if (acc[ACC_W-1]) begin
            z_c = '0;
        end
`endif
    end

    // Next-state logic for the accumulate / drain / output sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_ACC:   if (accept_c && last_c) state_next = S_DRAIN;
            S_DRAIN: if (!(p1_valid && p1_last)) state_next = S_OUT;
            S_OUT:   if (m_ready) state_next = S_ACC;
            default: state_next = S_ACC;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_ACC;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_z     <= '0;
        end else begin
            state   <= state_next;
            s_ready <= (state_next == S_ACC);
            m_valid <= (state_next == S_OUT);
            if (state == S_DRAIN && state_next == S_OUT) begin
                m_z <= z_c;
            end
        end
    end

    // Beat counter: advances per accepted beat, wraps after the last one, holds on bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (accept_c) begin
            beat_cnt <= last_c ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    // P1: register lane products with valid/first/last tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_first <= 1'b0;
            p1_last  <= 1'b0;
            for (int k = 0; k < int'(LANES); k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            p1_valid <= accept_c;
            if (accept_c) begin
                p1_first <= first_c;
                p1_last  <= last_c;
                for (int k = 0; k < int'(LANES); k++) begin
                    prod_q[k] <= prod_c[k];
                end
            end
        end
    end

    // P2: accumulate; a first-tagged beat restarts the sum, empty slots leave acc alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (p1_valid) begin
            acc <= p1_first ? lane_sum_c : acc + lane_sum_c;
        end
    end

endmodule

// File: tb/tb_fc_neuron_stream.sv
// Testbench for fc_neuron_stream at WIDTH=8, IN=5, LANES=2 (BEATS=3, ACC_W=19).
module tb_fc_neuron_stream;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned IN    = 5;
    localparam int unsigned LANES = 2;
    localparam int unsigned BEATS = 3;
    localparam int unsigned ACC_W = 19;

    typedef int vec_t [IN];

    logic                   clk;
    logic                   rst;
    logic                   s_valid;
    logic                   s_ready;
    logic [LANES*WIDTH-1:0] s_x;
    logic [LANES*WIDTH-1:0] s_w;
    logic                   m_valid;
    logic                   m_ready;
    logic [ACC_W-1:0]       m_z;

    int checks = 0;
    int errors = 0;

    logic [ACC_W-1:0] obs_q [$];
    int               vld_cycles = 0;

    fc_neuron_stream #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_x     (s_x),
        .s_w     (s_w),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_z     (m_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: records every result handshake and every m_valid cycle.
    always @(posedge clk) begin
        if (m_valid === 1'b1) vld_cycles++;
        if (m_valid === 1'b1 && m_ready === 1'b1) obs_q.push_back(m_z);
    end

    // Reference: plain dot product of the IN pairs, optional clamp, truncated to ACC_W.
    function automatic logic [ACC_W-1:0] model(input vec_t x, input vec_t w);
        longint s;
        s = 0;
        for (int i = 0; i < int'(IN); i++) s += longint'(x[i]) * longint'(w[i]);
`ifdef FC_NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        return ACC_W'(s);
    endfunction

    function automatic int rnd_s8();
        return int'($urandom_range(255)) - 128;
    endfunction

    // Drive one beat (entered at a negedge) and hold it until it is accepted.
    task automatic send_beat(input logic [LANES*WIDTH-1:0] xb, input logic [LANES*WIDTH-1:0] wb);
        int n;
        n = 0;
        s_x = xb;
        s_w = wb;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL beat_accept_timeout s_ready=%b required 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Send a whole vector; fill drives the out-of-range lanes; gap_n idle cycles before beat gap_b.
    task automatic send_vector(input vec_t x, input vec_t w, input int fill, input int gap_b, input int gap_n);
        logic [LANES*WIDTH-1:0] xb;
        logic [LANES*WIDTH-1:0] wb;
        int i;
        for (int b = 0; b < int'(BEATS); b++) begin
            if (b == gap_b) repeat (gap_n) @(negedge clk);
            for (int k = 0; k < int'(LANES); k++) begin
                i = b * int'(LANES) + k;
                xb[k*WIDTH +: WIDTH] = WIDTH'((i < int'(IN)) ? x[i] : fill);
                wb[k*WIDTH +: WIDTH] = WIDTH'((i < int'(IN)) ? w[i] : fill);
            end
            send_beat(xb, wb);
        end
    endtask

    // Send a vector, check latency, value, stability over hold stall cycles and release.
    task automatic run_vector(input string name, input vec_t x, input vec_t w, input int fill,
                              input int gap_b, input int gap_n, input int hold);
        logic [ACC_W-1:0] exp;
        logic [ACC_W-1:0] z0;
        int n;
        exp = model(x, w);
        send_vector(x, w, fill, gap_b, gap_n);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s latency_edge1 m_valid=%b required 0", name, m_valid);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s latency_edge2 m_valid=%b s_ready=%b required 0 0", name, m_valid, s_ready);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency_edge3 m_valid=%b required 1", name, m_valid);
        end
        n = 0;
        while (m_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s result_timeout m_valid=%b required 1", name, m_valid);
            return;
        end
        checks++;
        if (m_z !== exp) begin
            errors++;
            $display("FAIL %s value m_z=%0d required %0d", name, $signed(m_z), $signed(exp));
        end
        z0 = m_z;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_z !== z0) begin
                errors++;
                $display("FAIL %s stall_cycle%0d m_valid=%b s_ready=%b m_z=%0d required 1 0 %0d",
                         name, c, m_valid, s_ready, $signed(m_z), $signed(z0));
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release m_valid=%b s_ready=%b required 0 1", name, m_valid, s_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_z !== '0) begin
            errors++;
            $display("FAIL %s s_ready=%b m_valid=%b m_z=%0d required 0 0 0", name, s_ready, m_valid, m_z);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_x = '0;
        s_w = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release s_ready=%b m_valid=%b required 1 0", s_ready, m_valid);
        end
    endtask

    task automatic test_basic();
        vec_t x = '{1, 1, 1, 1, 1};
        vec_t w = '{1, 2, 3, 4, 5};
        run_vector("basic", x, w, 127, -1, 0, 0);
    endtask

    task automatic test_negative();
        vec_t x = '{-128, -128, -128, -128, -128};
        vec_t w = '{127, 127, 127, 127, 127};
        run_vector("negative", x, w, rnd_s8(), -1, 0, 0);
    endtask

    task automatic test_max();
        vec_t x = '{-128, -128, -128, -128, -128};
        vec_t w = '{-128, -128, -128, -128, -128};
        run_vector("max_pos", x, w, -128, -1, 0, 0);
    endtask

    task automatic test_stalls();
        vec_t x = '{1, 1, 1, 1, 1};
        vec_t w = '{1, 2, 3, 4, 5};
        run_vector("stalls", x, w, 127, 1, 3, 5);
    endtask

    task automatic test_mid_reset();
        vec_t x = '{1, 1, 1, 1, 1};
        vec_t w = '{1, 2, 3, 4, 5};
        logic [LANES*WIDTH-1:0] hv;
        hv = {8'd100, 8'd100};
        send_beat(hv, hv);
        send_beat(hv, hv);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_vector_rst_async");
        @(negedge clk);
        check_reset_outputs("mid_vector_rst_hold");
        #3 rst = 1'b0;
        @(negedge clk);
        run_vector("after_mid_reset", x, w, 127, -1, 0, 0);
    endtask

    task automatic test_out_reset();
        vec_t xm = '{-128, -128, -128, -128, -128};
        vec_t x  = '{1, 1, 1, 1, 1};
        vec_t w  = '{1, 2, 3, 4, 5};
        send_vector(xm, xm, 0, -1, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_output_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vector("after_out_reset", x, w, -7, -1, 0, 0);
    endtask

    task automatic test_back_to_back();
        vec_t x1 = '{1, 1, 1, 1, 1};
        vec_t w1 = '{1, 2, 3, 4, 5};
        vec_t x2 = '{-128, -128, -128, -128, -128};
        vec_t w2 = '{127, 127, 127, 127, 127};
        obs_q.delete();
        vld_cycles = 0;
        m_ready = 1'b1;
        send_vector(x1, w1, 127, -1, 0);
        send_vector(x2, w2, 55, -1, 0);
        repeat (8) @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (obs_q.size() != 2 || vld_cycles != 2) begin
            errors++;
            $display("FAIL b2b_count results=%0d valid_cycles=%0d required 2 2", obs_q.size(), vld_cycles);
        end
        if (obs_q.size() == 2) begin
            checks++;
            if (obs_q[0] !== model(x1, w1) || obs_q[1] !== model(x2, w2)) begin
                errors++;
                $display("FAIL b2b_order got %0d,%0d required %0d,%0d", $signed(obs_q[0]),
                         $signed(obs_q[1]), $signed(model(x1, w1)), $signed(model(x2, w2)));
            end
        end
    endtask

    task automatic test_random();
        vec_t x;
        vec_t w;
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < int'(IN); i++) begin
                x[i] = rnd_s8();
                w[i] = rnd_s8();
            end
            run_vector($sformatf("random%0d", v), x, w, rnd_s8(), int'($urandom_range(2)),
                       int'($urandom_range(3)), int'($urandom_range(3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_max();
        test_stalls();
        test_mid_reset();
        test_out_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1);
    end

endmodule
